// File: rtl/spectrum_frame_capture_pkg.sv
// dav_pkg: shared sizes, magnitude type, capture FSM states and the bar merge rule.
package dav_pkg;
  localparam int N = 16;
  localparam int MAG_W = 14;
  typedef logic [MAG_W-1:0] mag_t;
  typedef enum logic [1:0] {IDLE, WAIT_DONE, UPDATE} fc_state_t;
  // Decay of at least 1 for any nonzero bar, so small bars still fall to zero;
  // dec <= b always holds, so the subtraction cannot underflow.
  function automatic mag_t bar_merge(mag_t b, mag_t s, int sh);
    mag_t dec;
    mag_t decayed;
    dec = b >> sh;
    if (dec == '0 && b != '0) dec = mag_t'(1);
    decayed = b - dec;
    return (s > decayed) ? s : decayed;
  endfunction
endpackage

// File: rtl/spectrum_frame_capture_if.sv
// spectrum_frame_capture_if: FFT handshake and bar bus of the frame capture block.
// master: the capture block (vsync/done/freq_samples in; start_toggle/bars/busy/timeout_err out).
// slave: the surrounding display/FFT side.
interface spectrum_frame_capture_if;
  import dav_pkg::*;
  logic vsync;
  logic done;
  mag_t [0:N-1] freq_samples;
  logic start_toggle;
  mag_t [0:N-1] bars;
  logic busy;
  logic timeout_err;
  modport master (input vsync, done, freq_samples, output start_toggle, bars, busy, timeout_err);
  modport slave (output vsync, done, freq_samples, input start_toggle, bars, busy, timeout_err);
endinterface

// File: rtl/spectrum_frame_capture_sync_edge.sv
// sync_edge: two-flop synchronizer plus registered rising-edge detector.
// Ports: clk, rst_n (async active-low), i_d (async level), o_rise (one-cycle pulse per rising edge).
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);
  logic r_s1, r_s2, r_s3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {r_s1, r_s2, r_s3} <= '0;
    else {r_s1, r_s2, r_s3} <= {i_d, r_s1, r_s2};
  assign o_rise = r_s2 & ~r_s3;
endmodule

// File: rtl/spectrum_frame_capture.sv
// spectrum_frame_capture: per-vsync FFT request, wait for done, peak-hold/decay bar update.
// Ports: clk_50MHz, rst (async active-low), bus (master modport: vsync, done, freq_samples in;
// start_toggle, bars, busy, timeout_err out).
module spectrum_frame_capture
  import dav_pkg::*;
#(
  parameter int DECAY_SHIFT = 4,
  parameter int TIMEOUT = 2_000_000
) (
  input logic clk_50MHz,
  input logic rst,
  spectrum_frame_capture_if.master bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int IDX_W = $clog2(N);
  fc_state_t r_state, w_state_nx;
  logic r_vsync_q, r_toggle, r_busy, r_err;
  logic w_vs_rise, w_done_rise, w_toggle_nx, w_err_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  mag_t [0:N-1] r_bars;
  assign w_vs_rise = bus.vsync & ~r_vsync_q;
  sync_edge u_done (.clk(clk_50MHz), .rst_n(rst), .i_d(bus.done), .o_rise(w_done_rise));
  always_comb begin
    w_state_nx = r_state;
    w_toggle_nx = r_toggle;
    w_cnt_nx = r_cnt;
    w_idx_nx = r_idx;
    w_err_nx = r_err;
    case (r_state)
      IDLE:
        if (w_vs_rise) begin
          w_state_nx = WAIT_DONE;
          w_toggle_nx = ~r_toggle;
          w_cnt_nx = '0;
        end
      WAIT_DONE:
        if (w_done_rise) begin
          w_state_nx = UPDATE;
          w_idx_nx = '0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_state_nx = IDLE;
          w_err_nx = 1'b1;
        end else w_cnt_nx = r_cnt + 1'b1;
      UPDATE: begin
        w_idx_nx = r_idx + 1'b1;
        if (r_idx == IDX_W'(N - 1)) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_50MHz or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_vsync_q <= 1'b0;
      r_toggle <= 1'b0;
      r_busy <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_idx <= '0;
      r_bars <= '0;
    end else begin
      r_state <= w_state_nx;
      r_vsync_q <= bus.vsync;
      r_toggle <= w_toggle_nx;
      r_busy <= w_state_nx != IDLE;
      r_err <= w_err_nx;
      r_cnt <= w_cnt_nx;
      r_idx <= w_idx_nx;
      if (r_state == UPDATE) r_bars[r_idx] <= bar_merge(r_bars[r_idx], bus.freq_samples[r_idx], DECAY_SHIFT);
    end
  assign bus.start_toggle = r_toggle;
  assign bus.bars = r_bars;
  assign bus.busy = r_busy;
  assign bus.timeout_err = r_err;
endmodule
